// File: rtl/memory_stage_if.sv
// Memory-stage bundle: upstream operands, data-memory port, writeback and redirect.
interface memory_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] wd_me;
  logic [4:0]      rd;
  logic            mem_we;
  logic            mem_reg;
  logic            me_we;
  logic            pc_r;
  logic [XLEN-1:0] pc_disp;
  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_ack;
  logic [XLEN-1:0] dm_rdata;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [XLEN-1:0] bp_mem;
  logic            stall;
  logic            pc_r_f;
  logic [XLEN-1:0] pc_disp_f;
  logic [1:0]      err;

  modport master (
    output alu_out, wd_me, rd, mem_we, mem_reg, me_we, pc_r, pc_disp, dm_ack, dm_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, wb_data, wb_rd, wb_we, bp_mem, stall,
           pc_r_f, pc_disp_f, err
  );

  modport slave (
    input  alu_out, wd_me, rd, mem_we, mem_reg, me_we, pc_r, pc_disp, dm_ack, dm_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, wb_data, wb_rd, wb_we, bp_mem, stall,
           pc_r_f, pc_disp_f, err
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues loads/stores, stalls on slow memory with timeout
// abort, flags misalignment, and registers the writeback.
module memory_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  memory_stage_if.slave bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] lat_addr;
  logic [XLEN-1:0] lat_wdata;
  logic [4:0]      lat_rd;
  logic            lat_we;
  logic            lat_reg;
  logic            lat_me_we;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic [4:0]      op_rd;
  logic            op_we;
  logic            op_reg;
  logic            op_me_we;
  logic            mem_op;
  logic            is_load;
  logic            req;
  logic            misalign;
  logic            abort;
  logic            done;
  logic [XLEN-1:0] wb_val;
  logic            wb_we_nxt;

  // Operand source: live inputs in IDLE, latched copy while waiting on memory
  always_comb begin
    op_addr   = bus.alu_out;
    op_wdata  = bus.wd_me;
    op_rd     = bus.rd;
    op_we     = bus.mem_we;
    op_reg    = bus.mem_reg;
    op_me_we  = bus.me_we;
    req       = 1'b0;
    misalign  = 1'b0;
    abort     = 1'b0;
    done      = 1'b1;
    if (state == WAIT) begin
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
      op_rd    = lat_rd;
      op_we    = lat_we;
      op_reg   = lat_reg;
      op_me_we = lat_me_we;
    end
    mem_op  = op_we | op_reg;
    is_load = op_reg & ~op_we;
    if (state == WAIT) begin
      req   = 1'b1;
      abort = ~bus.dm_ack && (cnt == CW'(TIMEOUT - 1));
      done  = bus.dm_ack | abort;
    end else begin
      req      = rst & mem_op & (op_addr[1:0] == 2'b00);
      misalign = mem_op & (op_addr[1:0] != 2'b00);
      done     = ~req | bus.dm_ack;
    end
    // Loads return memory data only when acknowledged; aborts and misaligned loads yield 0
    if (is_load) wb_val = (req && bus.dm_ack) ? bus.dm_rdata : '0;
    else         wb_val = op_addr;
    wb_we_nxt = op_me_we & ~op_we;
  end

  assign bus.dm_req    = req;
  assign bus.dm_we     = req & op_we;
  assign bus.dm_addr   = op_addr;
  assign bus.dm_wdata  = op_wdata;
  assign bus.stall     = ~done;
  assign bus.bp_mem    = op_addr;
  assign bus.pc_r_f    = bus.pc_r & done;
  assign bus.pc_disp_f = bus.pc_disp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_rd      <= '0;
      lat_we      <= 1'b0;
      lat_reg     <= 1'b0;
      lat_me_we   <= 1'b0;
      bus.err     <= 2'b00;
      bus.wb_data <= '0;
      bus.wb_rd   <= '0;
      bus.wb_we   <= 1'b0;
    end else begin
      if (misalign) bus.err[1] <= 1'b1;
      if (abort)    bus.err[0] <= 1'b1;
      // Stalled cycles insert a bubble and hold the last writeback value
      if (done) begin
        bus.wb_data <= wb_val;
        bus.wb_rd   <= op_rd;
        bus.wb_we   <= wb_we_nxt;
      end else begin
        bus.wb_we   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (req && !bus.dm_ack) begin
            state     <= WAIT;
            cnt       <= '0;
            lat_addr  <= bus.alu_out;
            lat_wdata <= bus.wd_me;
            lat_rd    <= bus.rd;
            lat_we    <= bus.mem_we;
            lat_reg   <= bus.mem_reg;
            lat_me_we <= bus.me_we;
          end
        end
        WAIT: begin
          if (done) state <= IDLE;
          else      cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; writebacks are checked by a queue-based monitor.
module tb_memory_stage;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  memory_stage_if #(.XLEN(XLEN)) bus ();

  memory_stage #(.XLEN(XLEN), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  total = 0;
  int  bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd);
    mon_e.data = data;
    mon_e.rd   = rd;
    exp_q.push_back(mon_e);
  endtask

  task automatic drv(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                     input logic we, input logic ld, input logic mwe, input logic ack,
                     input logic [31:0] rdata, input logic pcr);
    bus.alu_out  = alu;
    bus.wd_me    = wd;
    bus.rd       = rd;
    bus.mem_we   = we;
    bus.mem_reg  = ld;
    bus.me_we    = mwe;
    bus.dm_ack   = ack;
    bus.dm_rdata = rdata;
    bus.pc_r     = pcr;
    bus.pc_disp  = 32'h40;
  endtask

  task automatic idle();
    drv(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: every registered writeback must match the oldest expectation
  always @(negedge clk) begin
    if (rst && bus.wb_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got data 0x%08h rd %0d expected no writeback", bus.wb_data, bus.wb_rd);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_data", bus.wb_data, e.data);
        check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
      end
    end
  end

  initial begin
    // Reset with an aligned load presented: nothing may be requested
    drv(32'h100, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 1'b0);
    #1;
    check("rst_dm_req", 32'(bus.dm_req), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_wb_we", 32'(bus.wb_we), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ALU op
    drv(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("alu_dm_req", 32'(bus.dm_req), 32'd0);
    check("alu_stall", 32'(bus.stall), 32'd0);
    check("alu_bp_mem", bus.bp_mem, 32'h1234);
    expect_wb(32'h1234, 5'd5);

    // Stray ack with no request
    @(negedge clk);
    idle();
    bus.dm_ack = 1'b1;
    #1;
    check("stray_ack_dm_req", 32'(bus.dm_req), 32'd0);
    check("stray_ack_stall", 32'(bus.stall), 32'd0);

    // Zero-wait load
    @(negedge clk);
    drv(32'h100, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    #1;
    check("ld_dm_req", 32'(bus.dm_req), 32'd1);
    check("ld_dm_we", 32'(bus.dm_we), 32'd0);
    check("ld_dm_addr", bus.dm_addr, 32'h100);
    check("ld_stall", 32'(bus.stall), 32'd0);
    check("ld_pc_r_f", 32'(bus.pc_r_f), 32'd1);
    expect_wb(32'hCAFEF00D, 5'd7);

    // Store acknowledged three cycles after the request
    @(negedge clk);
    drv(32'h200, 32'hAA, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    check("st_stall0", 32'(bus.stall), 32'd1);
    check("st_dm_we0", 32'(bus.dm_we), 32'd1);
    check("st_dm_addr0", bus.dm_addr, 32'h200);
    check("st_dm_wdata0", bus.dm_wdata, 32'hAA);
    check("st_pc_r_f", 32'(bus.pc_r_f), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv(32'hDEAD0000, 32'h55, 5'd9, 1'b0, 1'b0, 1'b1, (i == 2), 32'h0, 1'b0);
      #1;
      check("st_stall", 32'(bus.stall), (i == 2) ? 32'd0 : 32'd1);
      check("st_dm_req", 32'(bus.dm_req), 32'd1);
      check("st_dm_we", 32'(bus.dm_we), 32'd1);
      check("st_dm_addr", bus.dm_addr, 32'h200);
      check("st_dm_wdata", bus.dm_wdata, 32'hAA);
      check("st_bp_mem", bus.bp_mem, 32'h200);
    end

    // Both store and load set: behaves as a store
    @(negedge clk);
    drv(32'h208, 32'h77, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0);
    #1;
    check("both_dm_we", 32'(bus.dm_we), 32'd1);
    check("both_stall", 32'(bus.stall), 32'd0);

    // Misaligned load
    @(negedge clk);
    drv(32'h102, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0);
    #1;
    check("mis_dm_req", 32'(bus.dm_req), 32'd0);
    check("mis_stall", 32'(bus.stall), 32'd0);
    expect_wb(32'h0, 5'd4);
    @(negedge clk);
    idle();
    #1;
    check("mis_err", 32'(bus.err), 32'd2);

    // Reset in the middle of a wait
    @(negedge clk);
    drv(32'h300, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("rw_stall_req", 32'(bus.stall), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("rw_stall_wait", 32'(bus.stall), 32'd1);
    check("rw_dm_addr", bus.dm_addr, 32'h300);
    #2;
    rst = 1'b0;
    #1;
    check("rw_dm_req", 32'(bus.dm_req), 32'd0);
    check("rw_stall", 32'(bus.stall), 32'd0);
    check("rw_wb_we", 32'(bus.wb_we), 32'd0);
    check("rw_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drv(32'h55, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    expect_wb(32'h55, 5'd2);

    // Load that never gets acknowledged
    @(negedge clk);
    drv(32'h104, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
    #1;
    check("to_stall_req", 32'(bus.stall), 32'd1);
    check("to_err_before", 32'(bus.err), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idle();
      bus.dm_rdata = 32'hFFFFFFFF;
      #1;
      check("to_stall", 32'(bus.stall), (k == 15) ? 32'd0 : 32'd1);
      check("to_dm_req", 32'(bus.dm_req), 32'd1);
      if (k == 15) expect_wb(32'h0, 5'd9);
    end
    @(negedge clk);
    drv(32'hABC, 32'h0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    check("to_err", 32'(bus.err), 32'd1);
    check("to_after_dm_req", 32'(bus.dm_req), 32'd0);
    check("redir_pc_r_f", 32'(bus.pc_r_f), 32'd1);
    check("redir_pc_disp_f", bus.pc_disp_f, 32'h40);
    expect_wb(32'hABC, 5'd10);

    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
